// File: rtl/bcd_disp_scan_pkg.sv
// Shared cymometer display definitions: segment codes, shift FSM states and frame width.
package bcd_disp_scan_pkg;

    localparam int unsigned FRAME_W = 16;

    // Common-anode, active-low, bit order {dp, g, f, e, d, c, b, a}
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLatch
    } state_e;

endpackage

// File: rtl/bcd_disp_scan_seg7_decode.sv
// BCD nibble to active-low 7-segment code; non-decimal nibbles show a dash.
module seg7_decode
    import bcd_disp_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (nibble_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_disp_scan.sv
// 8-digit BCD display scanner: latches a packed BCD word, blanks leading zeros and
// shifts {select, segment} frames into two cascaded 74HC595 registers.
module bcd_disp_scan
    import bcd_disp_scan_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned SCAN_HZ  = 1000,
    parameter int unsigned SCLK_DIV = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] bcd_in,
    input  logic        bcd_vld,
    output logic        SH_CP,
    output logic        ST_CP,
    output logic        DS,
    output logic        busy
);

    localparam int unsigned SCAN_DIV = CLK_FREQ / SCAN_HZ;
    localparam int unsigned SCAN_W   = $clog2(SCAN_DIV);
    localparam int unsigned DIV_W    = $clog2(2 * SCLK_DIV);
    localparam int unsigned BIT_W    = $clog2(FRAME_W);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * SCLK_DIV - 1);
    localparam logic [DIV_W-1:0]  HALF_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_TOP   = BIT_W'(FRAME_W - 1);

    logic [31:0]        disp_q;
    logic [SCAN_W-1:0]  scan_q;
    logic               tick;
    logic [2:0]         digit_q;
    state_e             state_q;
    logic [FRAME_W-1:0] word_q;
    logic [BIT_W-1:0]   bit_q;
    logic [DIV_W-1:0]   div_q;
    logic               sh_cp_q, st_cp_q, ds_q, busy_q;

    logic [2:0]         top_idx;
    logic               blank;
    logic [3:0]         nibble;
    logic [7:0]         seg;
    logic [7:0]         sel;
    logic [FRAME_W-1:0] word_next;

    assign tick = (scan_q == SCAN_LAST);

    always_ff @(posedge Clk) begin
        if (Rst || tick) begin
            scan_q <= '0;
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            disp_q <= '0;
        end else if (bcd_vld) begin
            disp_q <= bcd_in;
        end
    end

    // Highest nonzero digit; digit 0 is never blanked since top_idx >= 0.
    always_comb begin
        top_idx = '0;
        for (int k = 0; k < 8; k++) begin
            if (disp_q[4*k +: 4] != 4'd0) begin
                top_idx = 3'(k);
            end
        end
    end

    assign blank     = (digit_q > top_idx);
    assign nibble    = disp_q[{digit_q, 2'b00} +: 4];
    assign sel       = ~(8'b1 << digit_q);
    assign word_next = {sel, seg};

    seg7_decode u_seg7_decode (
        .nibble_i (nibble),
        .blank_i  (blank),
        .seg_o    (seg)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            word_q  <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            sh_cp_q <= 1'b0;
            st_cp_q <= 1'b0;
            ds_q    <= 1'b0;
            busy_q  <= 1'b0;
            digit_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (tick) begin
                        word_q  <= word_next;
                        bit_q   <= BIT_TOP;
                        div_q   <= '0;
                        sh_cp_q <= 1'b0;
                        ds_q    <= word_next[FRAME_W-1];
                        busy_q  <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    // DS only moves at bit boundaries, where SH_CP drops back low.
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        sh_cp_q <= 1'b0;
                        if (bit_q == '0) begin
                            st_cp_q <= 1'b1;
                            state_q <= StLatch;
                        end else begin
                            bit_q <= bit_q - 1'b1;
                            ds_q  <= word_q[bit_q - 1'b1];
                        end
                    end else begin
                        div_q   <= div_q + 1'b1;
                        sh_cp_q <= (div_q >= HALF_LAST);
                    end
                end
                StLatch: begin
                    if (div_q == HALF_LAST) begin
                        div_q   <= '0;
                        st_cp_q <= 1'b0;
                        ds_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        digit_q <= digit_q + 1'b1;
                        state_q <= StIdle;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign SH_CP = sh_cp_q;
    assign ST_CP = st_cp_q;
    assign DS    = ds_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_bcd_disp_scan.sv
// Directed bench for bcd_disp_scan: decodes shifted 595 frames and compares against hand tables.
module tb_bcd_disp_scan;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] bcd_in = '0;
    logic        bcd_vld = 1'b0;
    logic        SH_CP, ST_CP, DS, busy;

    int checks = 0;
    int errors = 0;

    bcd_disp_scan #(
        .CLK_FREQ (1000),
        .SCAN_HZ  (10),
        .SCLK_DIV (2)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .bcd_in  (bcd_in),
        .bcd_vld (bcd_vld),
        .SH_CP   (SH_CP),
        .ST_CP   (ST_CP),
        .DS      (DS),
        .busy    (busy)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        Rst     = 1'b1;
        bcd_vld = 1'b0;
        repeat (3) @(negedge Clk);
        check_eq("reset_outputs", {28'd0, SH_CP, ST_CP, DS, busy}, 32'd0);
        Rst = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] val);
        @(negedge Clk);
        bcd_in  = val;
        bcd_vld = 1'b1;
        @(negedge Clk);
        bcd_vld = 1'b0;
    endtask

    // Waits for a frame, collects DS on each SH_CP rising edge until busy drops.
    // Optionally pulses bcd_vld with vld_val on cycle vld_at of the frame.
    task automatic capture_frame(input int vld_at, input logic [31:0] vld_val,
                                 output logic [15:0] word, output int edges,
                                 output int st_len, output int wait_cyc, output int pre_st);
        logic prev_sh;
        int   cyc;
        logic done;
        word     = '0;
        edges    = 0;
        st_len   = 0;
        wait_cyc = 0;
        pre_st   = 0;
        done     = 1'b0;
        while (!busy && wait_cyc < 400) begin
            @(negedge Clk);
            wait_cyc++;
            if (ST_CP) pre_st++;
        end
        if (!busy) begin
            check_eq("frame_start_timeout", 32'd0, 32'd1);
        end else begin
            prev_sh = SH_CP;
            cyc     = 0;
            while (!done && cyc < 200) begin
                @(negedge Clk);
                cyc++;
                if (cyc == vld_at) begin
                    bcd_in  = vld_val;
                    bcd_vld = 1'b1;
                end else begin
                    bcd_vld = 1'b0;
                end
                if (!busy) begin
                    done = 1'b1;
                end else begin
                    if (SH_CP && !prev_sh) begin
                        word = {word[14:0], DS};
                        edges++;
                    end
                    if (ST_CP) st_len++;
                    prev_sh = SH_CP;
                end
            end
            if (!done) check_eq("frame_end_timeout", 32'd0, 32'd1);
        end
    endtask

    logic [15:0] exp2 [9] = '{16'hFE92, 16'hFD99, 16'hFBB0, 16'hF7A4, 16'hEFF9,
                              16'hDFFF, 16'hBFFF, 16'h7FFF, 16'hFE92};
    logic [15:0] exp3 [8] = '{16'hFEC0, 16'hFDC0, 16'hFBC0, 16'hF7BF,
                              16'hEFFF, 16'hDFFF, 16'hBFFF, 16'h7FFF};
    logic [15:0] exp6 [8] = '{16'hFE90, 16'hFD90, 16'hFB90, 16'hF790,
                              16'hEF90, 16'hDF90, 16'hBF90, 16'h7F90};

    initial begin
        logic [15:0] w;
        int e, s, wc, ps;
        int n;
        logic prev;

        // 1: reset value shows "0" on digit 0
        reset_dut();
        capture_frame(-1, '0, w, e, s, wc, ps);
        check_eq("s1_first_frame_delay", {31'd0, (wc >= 99 && wc <= 101)}, 32'd1);
        check_eq("s1_word", {16'd0, w}, 32'h0000FEC0);
        check_eq("s1_edges", e, 16);
        check_eq("s1_st_cp_len", s, 2);
        check_eq("s1_no_early_st", ps, 0);

        // 2: blanking of 00012345 across all digits, then wrap
        reset_dut();
        strobe(32'h00012345);
        for (int i = 0; i < 9; i++) begin
            capture_frame(-1, '0, w, e, s, wc, ps);
            check_eq($sformatf("s2_frame%0d", i), {16'd0, w}, {16'd0, exp2[i]});
        end
        check_eq("s2_last_edges", e, 16);

        // 3: invalid nibble counts as nonzero, lower zeros shown
        reset_dut();
        strobe(32'h0000A000);
        for (int i = 0; i < 8; i++) begin
            capture_frame(-1, '0, w, e, s, wc, ps);
            check_eq($sformatf("s3_frame%0d", i), {16'd0, w}, {16'd0, exp3[i]});
        end

        // 4: new value mid-frame only affects the following frame
        reset_dut();
        strobe(32'h00012345);
        capture_frame(-1, '0, w, e, s, wc, ps);
        check_eq("s4_digit0", {16'd0, w}, 32'h0000FE92);
        capture_frame(-1, '0, w, e, s, wc, ps);
        check_eq("s4_digit1", {16'd0, w}, 32'h0000FD99);
        capture_frame(10, 32'h00067890, w, e, s, wc, ps);
        check_eq("s4_digit2_old", {16'd0, w}, 32'h0000FBB0);
        capture_frame(-1, '0, w, e, s, wc, ps);
        check_eq("s4_digit3_new", {16'd0, w}, 32'h0000F7F8);

        // 5: reset mid-shift aborts without a latch pulse
        reset_dut();
        strobe(32'h00012345);
        n    = 0;
        prev = 1'b0;
        for (int c = 0; c < 400 && n < 7; c++) begin
            @(negedge Clk);
            if (SH_CP && !prev) n++;
            prev = SH_CP;
        end
        check_eq("s5_edges_before_rst", n, 7);
        Rst = 1'b1;
        @(negedge Clk);
        check_eq("s5_abort_outputs", {28'd0, SH_CP, ST_CP, DS, busy}, 32'd0);
        Rst = 1'b0;
        capture_frame(-1, '0, w, e, s, wc, ps);
        check_eq("s5_no_st_pulse", ps, 0);
        check_eq("s5_word", {16'd0, w}, 32'h0000FEC0);

        // 6: all nines, select walks FE..7F
        reset_dut();
        strobe(32'h99999999);
        for (int i = 0; i < 8; i++) begin
            capture_frame(-1, '0, w, e, s, wc, ps);
            check_eq($sformatf("s6_frame%0d", i), {16'd0, w}, {16'd0, exp6[i]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
